// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg: shared state encoding, defaults and result-RAM addressing for mul_ctrl
package mul_ctrl_pkg;
    localparam int MAX_PAIRS_DEF = 7;
    localparam int TIMEOUT_DEF   = 4096;
    localparam int AW            = 4;

    typedef enum logic [3:0] {
        S_IDLE, S_TERM, S_START, S_WAIT, S_RD_LO, S_RD_HI, S_CAP, S_OUT, S_CLEAR, S_ERR
    } state_t;

    function automatic logic [AW-1:0] word_addr(logic [AW-1:0] base, logic [AW-1:0] k, logic hi);
        return base + {k[AW-2:0], hi};
    endfunction
endpackage

// File: rtl/mul_ctrl_wdog.sv
// mul_ctrl_wdog: loadable down-counter that expires TIMEOUT-1 decrements after a load
module mul_ctrl_wdog
    import mul_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic run,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    // Reload when the engine is started, then count down while waiting and hold at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= W'(TIMEOUT - 1);
        else if (run && !expired)
            cnt <= cnt - 1'b1;
    end

    assign expired = cnt == '0;
endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl: host sequencer feeding the Booth multiplier FIFOs and streaming products back from its result RAM
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int MAX_PAIRS = MAX_PAIRS_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          h_wr,
    input  logic [31:0]   h_cand,
    input  logic [31:0]   h_lier,
    input  logic          h_go,
    output logic          h_full,
    output logic          h_busy,
    output logic          h_done,
    output logic          h_err,
    output logic          r_valid,
    output logic [63:0]   r_data,
    input  logic          r_ready,
    output logic          cand_wr_en,
    output logic [31:0]   cand_din,
    output logic          lier_wr_en,
    output logic [31:0]   lier_din,
    output logic          op_start,
    output logic          op_clear,
    input  logic          op_done,
    output logic          res_rd_en,
    output logic [AW-1:0] res_raddr,
    input  logic [31:0]   res_rdata
);
    state_t        state;
    logic [AW-1:0] count;
    logic [AW-1:0] idx;
    logic [AW-1:0] base;
    logic [31:0]   lo_word;
    logic          push;
    logic          expired;

    assign push   = h_wr && (count < AW'(MAX_PAIRS)) && !h_err;
    assign h_full = count == AW'(MAX_PAIRS);
    assign h_busy = state != S_IDLE;

    mul_ctrl_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state == S_START),
        .run     (state == S_WAIT),
        .expired (expired)
    );

    // Sequencer; read strobes are issued on entry to RD_LO/RD_HI so RAM data lands in RD_HI/CAP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            count      <= '0;
            idx        <= '0;
            base       <= '0;
            lo_word    <= '0;
            h_done     <= 1'b0;
            h_err      <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            cand_wr_en <= 1'b0;
            cand_din   <= '0;
            lier_wr_en <= 1'b0;
            lier_din   <= '0;
            op_start   <= 1'b0;
            op_clear   <= 1'b0;
            res_rd_en  <= 1'b0;
            res_raddr  <= '0;
        end else begin
            cand_wr_en <= 1'b0;
            lier_wr_en <= 1'b0;
            op_start   <= 1'b0;
            op_clear   <= 1'b0;
            h_done     <= 1'b0;
            res_rd_en  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (push) begin
                        cand_wr_en <= 1'b1;
                        lier_wr_en <= 1'b1;
                        cand_din   <= h_cand;
                        lier_din   <= h_lier;
                        count      <= count + 1'b1;
                    end
                    if (h_go && (count != '0 || push))
                        state <= S_TERM;
                end
                S_TERM: begin
                    cand_wr_en <= 1'b1;
                    lier_wr_en <= 1'b1;
                    cand_din   <= '0;
                    lier_din   <= '0;
                    state      <= S_START;
                end
                S_START: begin
                    op_start <= 1'b1;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (op_done) begin
                        idx       <= '0;
                        res_rd_en <= 1'b1;
                        res_raddr <= word_addr(base, '0, 1'b0);
                        state     <= S_RD_LO;
                    end else if (expired) begin
                        op_clear <= 1'b1;
                        h_err    <= 1'b1;
                        state    <= S_ERR;
                    end
                end
                S_RD_LO: begin
                    res_rd_en <= 1'b1;
                    res_raddr <= word_addr(base, idx, 1'b1);
                    state     <= S_RD_HI;
                end
                S_RD_HI: begin
                    lo_word <= res_rdata;
                    state   <= S_CAP;
                end
                S_CAP: begin
                    r_valid <= 1'b1;
                    r_data  <= {res_rdata, lo_word};
                    state   <= S_OUT;
                end
                S_OUT: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        if (idx == count - 1'b1) begin
                            op_clear <= 1'b1;
                            h_done   <= 1'b1;
                            state    <= S_CLEAR;
                        end else begin
                            idx       <= idx + 1'b1;
                            res_rd_en <= 1'b1;
                            res_raddr <= word_addr(base, idx + 1'b1, 1'b0);
                            state     <= S_RD_LO;
                        end
                    end
                end
                S_CLEAR: begin
                    base  <= base + {count[AW-2:0], 1'b0};
                    count <= '0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    count <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: table-driven and randomized checks of mul_ctrl against a host-level product/address model
module tb_mul_ctrl;
    localparam int MAXP = 7;
    localparam int TMO  = 4096;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        h_wr = 1'b0, h_go = 1'b0, r_ready = 1'b0;
    logic [31:0] h_cand = '0, h_lier = '0;
    logic        h_full, h_busy, h_done, h_err, r_valid;
    logic [63:0] r_data;
    logic        cand_wr_en, lier_wr_en, op_start, op_clear, res_rd_en;
    logic [31:0] cand_din, lier_din;
    logic [3:0]  res_raddr;
    logic        op_done;
    logic [31:0] res_rdata;

    mul_ctrl dut (
        .clk(clk), .reset_n(reset_n), .h_wr(h_wr), .h_cand(h_cand), .h_lier(h_lier), .h_go(h_go),
        .h_full(h_full), .h_busy(h_busy), .h_done(h_done), .h_err(h_err),
        .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
        .cand_wr_en(cand_wr_en), .cand_din(cand_din), .lier_wr_en(lier_wr_en), .lier_din(lier_din),
        .op_start(op_start), .op_clear(op_clear), .op_done(op_done),
        .res_rd_en(res_rd_en), .res_raddr(res_raddr), .res_rdata(res_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 64'(x * y);
    endfunction

    // Interface monitor: counts strobes and logs read addresses
    int          n_push = 0, n_sent = 0, n_start = 0, n_clear = 0, n_done = 0, n_rd = 0, n_mis = 0;
    longint      cyc = 0, t_start = 0, t_clear = 0;
    logic [3:0]  ra_arr [4096];
    always @(posedge clk) begin
        cyc++;
        if (cand_wr_en !== lier_wr_en) n_mis++;
        if (cand_wr_en === 1'b1) begin
            if (cand_din == 0 && lier_din == 0) n_sent++;
            else n_push++;
        end
        if (op_start === 1'b1) begin n_start++; t_start = cyc; end
        if (op_clear === 1'b1) begin n_clear++; t_clear = cyc; end
        if (h_done === 1'b1) n_done++;
        if (res_rd_en === 1'b1) begin ra_arr[n_rd % 4096] = res_raddr; n_rd++; end
    end

    // Engine stand-in: operand FIFOs, multiply until (0,0), result RAM with free-running write pointer
    logic [31:0] fq_c[$], fq_l[$];
    logic [31:0] ram [16];
    logic [3:0]  wp;
    logic [31:0] ea, eb;
    logic [63:0] ep;
    int          dly;
    bit          mute = 0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fq_c.delete(); fq_l.delete();
            wp = '0; dly = 0;
            op_done <= 1'b0; res_rdata <= '0;
        end else begin
            if (cand_wr_en) fq_c.push_back(cand_din);
            if (lier_wr_en) fq_l.push_back(lier_din);
            if (res_rd_en) res_rdata <= ram[res_raddr];
            if (op_clear) begin op_done <= 1'b0; dly = 0; end
            if (op_start) begin
                while (fq_c.size() > 0 && fq_l.size() > 0) begin
                    ea = fq_c.pop_front();
                    eb = fq_l.pop_front();
                    if (ea == 0 && eb == 0) break;
                    ep = prod(ea, eb);
                    ram[wp] = ep[31:0];
                    ram[wp + 4'd1] = ep[63:32];
                    wp = wp + 4'd2;
                end
                dly = mute ? 0 : int'($urandom_range(1, 20));
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) op_done <= 1'b1;
            end
        end
    end

    int          checks = 0, failures = 0;
    int          mcount = 0;
    logic [3:0]  mbase = '0;
    logic [31:0] pc[$], pl[$];
    logic [63:0] pe[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; h_wr = 1'b0; h_go = 1'b0; r_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outs", |{h_full, h_busy, h_done, h_err, r_valid, r_data, cand_wr_en, cand_din,
                          lier_wr_en, lier_din, op_start, op_clear, res_rd_en, res_raddr}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_idle", {h_busy, h_full, h_err, r_valid}, 0);
        mcount = 0;
        mbase = '0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_pairs(input int n);
        logic [31:0] a, b;
        pc.delete(); pl.delete(); pe.delete();
        for (int i = 0; i < n; i++) begin
            a = pick();
            b = pick();
            if (a == 0 && b == 0) b = 32'd1;
            pc.push_back(a); pl.push_back(b); pe.push_back(prod(a, b));
        end
    endtask

    // mode 0: r_ready held high, 1: random r_ready, 2: 10-cycle stall on first product
    task automatic run(input int mode, input bit go_last);
        int s_push, s_sent, s_start, s_clear, s_done, s_rd, s_rd2, acc, c, last;
        bit stalled;
        logic [63:0] held;
        logic [63:0] expq[$];
        s_push = n_push; s_sent = n_sent; s_start = n_start; s_clear = n_clear;
        s_done = n_done; s_rd = n_rd; acc = 0; stalled = 0; last = -1; s_rd2 = 0;
        for (int i = 0; i < pc.size(); i++) begin
            h_wr = 1'b1; h_cand = pc[i]; h_lier = pl[i];
            h_go = go_last && (i == pc.size() - 1);
            if (mcount < MAXP) begin mcount++; acc++; expq.push_back(pe[i]); end
            @(negedge clk);
            chk("h_full", h_full, mcount == MAXP);
        end
        h_wr = 1'b0;
        if (!go_last) begin h_go = 1'b1; @(negedge clk); end
        h_go = 1'b0;
        for (c = 0; c < 3000 && h_busy; c++) begin
            if (mode == 2 && r_valid && !stalled) begin
                stalled = 1; held = r_data; s_rd2 = n_rd; r_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    chk("stall_hold", {r_valid, r_data}, {1'b1, held});
                end
                chk("stall_no_rd", n_rd - s_rd2, 0);
                c += 10;
            end
            r_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (r_valid && r_ready) begin
                chk("r_data", r_data, expq.size() > 0 ? expq.pop_front() : 64'bx);
                if (mode == 0 && last >= 0) chk("r_rate", c - last, 4);
                last = c;
            end
            @(negedge clk);
        end
        r_ready = 1'b0;
        chk("run_end_busy", h_busy, 0);
        chk("prod_left", expq.size(), 0);
        chk("pushes", n_push - s_push, acc);
        chk("sentinel", n_sent - s_sent, 1);
        chk("op_start_cyc", n_start - s_start, 1);
        chk("op_clear_cyc", n_clear - s_clear, 1);
        chk("h_done_cyc", n_done - s_done, 1);
        chk("wr_pair", n_mis, 0);
        chk("rd_cnt", n_rd - s_rd, 2 * acc);
        for (int k = 0; k < 2 * acc && k < n_rd - s_rd; k++)
            chk("raddr", ra_arr[(s_rd + k) % 4096], 4'(mbase + 4'(k)));
        mbase = mbase + 4'(2 * acc);
        mcount = 0;
    endtask

    typedef struct {
        logic [31:0] cand;
        logic [31:0] lier;
        logic [63:0] prod;
        int          run_id;
    } vec_t;
    vec_t tbl [7];

    initial begin
        tbl[0] = '{32'd3,         32'd5,         64'h000000000000000F, 0};
        tbl[1] = '{32'hFFFFFFFE,  32'd7,         64'hFFFFFFFFFFFFFFF2, 1};
        tbl[2] = '{32'h7FFFFFFF,  32'd2,         64'h00000000FFFFFFFE, 1};
        tbl[3] = '{32'h80000000,  32'h80000000,  64'h4000000000000000, 2};
        tbl[4] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'h0000000000000001, 2};
        tbl[5] = '{32'hFFFFFFFF,  32'd1,         64'hFFFFFFFFFFFFFFFF, 2};
        tbl[6] = '{32'h00010000,  32'h00010000,  64'h0000000100000000, 2};

        do_reset();
        for (int r = 0; r < 3; r++) begin
            pc.delete(); pl.delete(); pe.delete();
            foreach (tbl[i]) if (tbl[i].run_id == r) begin
                pc.push_back(tbl[i].cand); pl.push_back(tbl[i].lier); pe.push_back(tbl[i].prod);
            end
            run(r == 2 ? 1 : 0, r == 2);
        end

        do_reset();
        for (int r = 0; r < 3; r++) begin
            rand_pairs(3);
            run(0, 0);
        end

        rand_pairs(MAXP + 1);
        run(0, 0);

        rand_pairs(2);
        run(2, 1);

        repeat (12) begin
            rand_pairs($urandom_range(1, MAXP));
            run($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        rand_pairs(2);
        h_wr = 1'b1; h_cand = pc[0]; h_lier = pl[0]; h_go = 1'b1;
        @(negedge clk);
        h_wr = 1'b0; h_go = 1'b0; r_ready = 1'b0;
        for (int c = 0; c < 200 && !r_valid; c++) @(negedge clk);
        chk("pre_rst_valid", r_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", r_valid, 0);
        chk("rst_mid_busy", h_busy, 0);
        do_reset();

        mute = 1;
        h_wr = 1'b1; h_cand = 32'd5; h_lier = 32'd6; h_go = 1'b1;
        @(negedge clk);
        h_wr = 1'b0; h_go = 1'b0;
        for (int c = 0; c < 6000 && !op_clear; c++) @(negedge clk);
        chk("wd_clear", op_clear, 1);
        chk("wd_err_set", h_err, 1);
        @(negedge clk);
        chk("wd_cycles", t_clear - t_start, TMO);
        chk("wd_idle", h_busy, 0);
        begin
            int s;
            s = n_push;
            h_wr = 1'b1; h_cand = 32'd9; h_lier = 32'd9;
            @(negedge clk);
            h_wr = 1'b0; h_go = 1'b1;
            @(negedge clk);
            h_go = 1'b0;
            chk("err_push_blocked", n_push - s, 0);
            chk("err_go_ignored", h_busy, 0);
            chk("err_sticky", h_err, 1);
        end
        mute = 0;
        do_reset();
        chk("err_cleared", h_err, 0);
        rand_pairs(2);
        run(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
Host-side sequencer for the Booth multiplier engine (mul_master) and its two operand FIFOs and result RAM.
- Collects up to MAX_PAIRS operand pairs from the host, pushes them into the multiplicand/multiplier FIFOs and appends a (0,0) sentinel.
- Pulses op_start, waits for op_done (with watchdog), reads each 64-bit product back from the 16x32 result RAM and streams it out with a valid/ready handshake.
- Issues op_clear to return the engine to IDLE.

Parameters:
MAX_PAIRS, 7, maximum user operand pairs per run; MAX_PAIRS+1 must not exceed FIFO depth, 2*MAX_PAIRS must not exceed 16.
TIMEOUT, 4096, cycles allowed in WAIT before error.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
h_wr  in  1  host push of one operand pair
h_cand  in  32  multiplicand for push
h_lier  in  32  multiplier for push
h_go  in  1  start a run
h_full  out  1  pair count == MAX_PAIRS
h_busy  out  1  state != IDLE
h_done  out  1  one-cycle pulse: run complete
h_err  out  1  sticky watchdog error
r_valid  out  1  product available
r_data  out  64  product {high word, low word}
r_ready  in  1  host accepts product
cand_wr_en  out  1  multiplicand FIFO push
cand_din  out  32  multiplicand FIFO data
lier_wr_en  out  1  multiplier FIFO push
lier_din  out  32  multiplier FIFO data
op_start  out  1  engine start
op_clear  out  1  engine clear
op_done  in  1  engine done
res_rd_en  out  1  result RAM read enable
res_raddr  out  4  result RAM read address
res_rdata  in  32  result RAM data, valid one cycle after res_rd_en

Behaviour:
- Reset values: all outputs 0; state IDLE; pair count 0; product index 0; base pointer 0; watchdog 0; h_err 0.
- States: IDLE, TERM, START, WAIT, RD_LO, RD_HI, CAP, OUT, CLEAR, ERR.
- IDLE:
  - h_wr with count < MAX_PAIRS and h_err == 0 asserts cand_wr_en and lier_wr_en in the same cycle, with din = h_cand/h_lier. Count then increments.
  - h_wr while h_full is ignored, with no push.
  - h_go with count > 0 goes to TERM. If h_wr and h_go arrive together, the push is accepted first, then TERM.
  - h_go with count == 0 is ignored.
- TERM: push sentinel (0,0) to both FIFOs for one cycle, then START.
- START: op_start = 1 for exactly one cycle, then WAIT. Watchdog is cleared.
- WAIT:
  - Watchdog increments each cycle.
  - op_done = 1 goes to RD_LO with index = 0.
  - Watchdog == TIMEOUT-1 without op_done goes to ERR.
  - h_wr and h_go are ignored outside IDLE.
- Address rule: the engine writes products sequentially (low word, then high word). Its write address is not reset by op_clear, so it continues across runs.
  - Controller keeps a 4-bit base pointer. Product k is at low = base+2k and high = base+2k+1, both mod 16 (wrap-around required).
- RD_LO: res_rd_en = 1, raddr = low address.
- RD_HI: res_rd_en = 1, raddr = high address; capture res_rdata as low word.
- CAP: capture res_rdata as high word, go to OUT.
- OUT:
  - r_valid = 1 and r_data stable until r_ready.
  - On r_valid & r_ready, index increments. If index == count-1, go to CLEAR, else RD_LO.
  - r_ready held 1 gives one product per 4 cycles.
- CLEAR:
  - op_clear = 1 for one cycle; h_done pulses in the same cycle.
  - base += 2*count (mod 16); count = 0; go to IDLE.
- ERR: op_clear = 1 for one cycle and h_err set. Then return to IDLE with count = 0.
  - h_err remains 1 and blocks pushes until reset_n, because the engine address is then unknown.
- Reset asserted mid-run: all state returns to reset values immediately. Partial products are discarded and r_valid drops.
- Product semantics: signed 32x32 to 64-bit two's complement.

Decomposition:
- Shared package: state encodings, MAX_PAIRS/TIMEOUT defaults, 4-bit RAM address width.
- One sub-module is natural: mul_ctrl_wdog, a loadable down-counter with clear and expire outputs. Everything else stays in mul_ctrl.

Test Plan:
- Push (3,5), h_go, r_ready=1 -> exactly one sentinel push; op_start one cycle; r_data = 64'h000000000000000F; h_done one pulse; op_clear one cycle.
- Push (-2,7), (0x7FFFFFFF,2) -> r_data = 64'hFFFFFFFFFFFFFFF2, then 64'h00000000FFFFFFFE, in order.
- Three runs of 3 pairs each -> third run reads addresses 12,13,14,15,0,1 (wrap); products correct.
- Push MAX_PAIRS+1 pairs -> h_full after 7th; 8th produces no FIFO write; count = 7.
- r_ready held low 10 cycles in OUT -> r_valid and r_data stable; no RAM reads until accept.
- op_done never asserted -> op_clear at WAIT cycle 4096, h_err = 1; subsequent h_wr ignored until reset_n pulse.
